// File: rtl/count_sequencer.sv
// count_sequencer: prescaled up/down digit counter with run/hold FSM, manual step and load.
module count_sequencer #(
  parameter int DIV_BASE  = 1000,
  parameter int MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic       i_dir,
  input  logic       i_step,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic [1:0] i_rate,
  output logic [3:0] o_digit,
  output logic       o_tick,
  output logic       o_wrap,
  output logic [1:0] o_state
);
  localparam logic [1:0]  IDLE = 2'b00;
  localparam logic [1:0]  RUN  = 2'b01;
  localparam logic [1:0]  HOLD = 2'b10;
  localparam logic [1:0]  BAD  = 2'b11;
  localparam logic [27:0] BASE = 28'(DIV_BASE);
  localparam logic [3:0]  MAXD = 4'(MAX_DIGIT);
  logic [1:0]  state_q, state_d;
  logic [27:0] presc_q, presc_d, term;
  logic [3:0]  digit_q, digit_d;
  logic        tick_q, tick_d, wrap_q, wrap_d, step_prev_q;
  logic        timed, manual, step, at_end;
  always_comb begin
    term    = (BASE << i_rate) - 28'd1;
    timed   = (state_q == RUN) && (presc_q >= term);
    manual  = ((state_q == IDLE) || (state_q == HOLD)) && i_step && !step_prev_q;
    step    = timed || manual;
    at_end  = i_dir ? (digit_q == MAXD) : (digit_q == 4'd0);
    state_d = (state_q == IDLE) ? (i_run ? RUN : IDLE) :
              (state_q == BAD)  ? IDLE : (i_run ? RUN : HOLD);
    presc_d = (state_q == RUN)  ? (timed ? 28'd0 : presc_q + 28'd1) :
              (state_q == HOLD) ? presc_q : 28'd0;
    digit_d = !step ? digit_q :
              at_end ? (i_dir ? 4'd0 : MAXD) :
              (i_dir ? digit_q + 4'd1 : digit_q - 4'd1);
    tick_d  = step;
    wrap_d  = step && at_end;
    // load wins over any step and leaves the FSM where it is
    if (i_load) begin
      digit_d = (i_load_val > MAXD) ? MAXD : i_load_val;
      presc_d = 28'd0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      state_d = (state_q == BAD) ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= 28'd0;
      digit_q     <= 4'd0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      step_prev_q <= i_step;
    end
  end
  assign o_digit = digit_q;
  assign o_tick  = tick_q;
  assign o_wrap  = wrap_q;
  assign o_state = state_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed stimulus with a cycle model checked every clock plus literal checkpoints.
module tb_count_sequencer;
  localparam int DB = 4;
  localparam int MX = 9;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_run = 1'b0, i_dir = 1'b0, i_step = 1'b0, i_load = 1'b0;
  logic [3:0] i_load_val = 4'd0;
  logic [1:0] i_rate = 2'd0;
  logic [3:0] o_digit;
  logic       o_tick, o_wrap;
  logic [1:0] o_state;
  int errors = 0;
  int checks = 0;
  int m_state = 0, m_digit = 0, m_phase = 0;
  bit m_prev = 0, m_tick = 0, m_wrap = 0;

  always #5 clk = ~clk;

  count_sequencer #(.DIV_BASE(DB), .MAX_DIGIT(MX)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_dir(i_dir), .i_step(i_step),
    .i_load(i_load), .i_load_val(i_load_val), .i_rate(i_rate),
    .o_digit(o_digit), .o_tick(o_tick), .o_wrap(o_wrap), .o_state(o_state)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: modes 0=idle 1=run 2=hold, digit arithmetic modulo MX+1
  task automatic model_step();
    int  period, nxt, old;
    bit  do_step;
    if (!rst_n) begin
      m_state = 0; m_digit = 0; m_phase = 0; m_prev = 0; m_tick = 0; m_wrap = 0;
      return;
    end
    period  = DB << i_rate;
    do_step = 0;
    nxt     = (m_state == 0 && !i_run) ? 0 : (i_run ? 1 : 2);
    if (m_state == 1) begin
      if (m_phase >= period - 1) begin
        do_step = 1;
        m_phase = 0;
      end else m_phase++;
    end else if (m_state == 0) m_phase = 0;
    if (m_state != 1 && i_step && !m_prev) do_step = 1;
    m_tick = 0;
    m_wrap = 0;
    if (i_load) begin
      m_digit = (int'(i_load_val) > MX) ? MX : int'(i_load_val);
      m_phase = 0;
    end else begin
      if (do_step) begin
        old     = m_digit;
        m_digit = i_dir ? (old + 1) % (MX + 1) : (old + MX) % (MX + 1);
        m_tick  = 1;
        m_wrap  = i_dir ? (m_digit < old) : (m_digit > old);
      end
      m_state = nxt;
    end
    m_prev = i_step;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("digit", int'(o_digit), m_digit);
    chk("tick",  int'(o_tick),  int'(m_tick));
    chk("wrap",  int'(o_wrap),  int'(m_wrap));
    chk("state", int'(o_state), m_state);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_digit", int'(o_digit), 0);
    chk("rst_state", int'(o_state), 0);
    // free-running up count at rate 0
    rst_n = 1; i_run = 1; i_dir = 1; i_rate = 0;
    tick();
    chk("enter_run", int'(o_state), 1);
    for (int k = 1; k <= 10; k++) begin
      repeat (4) tick();
      chk("up_digit", int'(o_digit), k % 10);
      chk("up_tick", int'(o_tick), 1);
      chk("up_wrap", int'(o_wrap), (k == 10) ? 1 : 0);
    end
    // down from 0 at rate 1
    i_dir = 0; i_rate = 1;
    repeat (8) tick();
    chk("down_wrap_digit", int'(o_digit), 9);
    chk("down_wrap_flag", int'(o_wrap), 1);
    repeat (8) tick();
    chk("down_digit", int'(o_digit), 8);
    chk("down_nowrap", int'(o_wrap), 0);
    // load clamp, then load on terminal count
    i_load = 1; i_load_val = 4'd12;
    tick();
    chk("load_clamp", int'(o_digit), 9);
    i_load = 0; i_rate = 0; i_dir = 1;
    repeat (3) tick();
    i_load = 1; i_load_val = 4'd3;
    tick();
    chk("load_tc_digit", int'(o_digit), 3);
    chk("load_tc_tick", int'(o_tick), 0);
    i_load = 0;
    repeat (3) tick();
    chk("load_tc_hold", int'(o_digit), 3);
    tick();
    chk("load_tc_next", int'(o_digit), 4);
    chk("load_tc_next_tick", int'(o_tick), 1);
    // hold mid-period, then resume
    repeat (2) tick();
    i_run = 0;
    repeat (10) tick();
    chk("hold_digit", int'(o_digit), 4);
    chk("hold_state", int'(o_state), 2);
    i_run = 1;
    tick();
    chk("resume_wait", int'(o_digit), 4);
    tick();
    chk("resume_step", int'(o_digit), 5);
    chk("resume_tick", int'(o_tick), 1);
    // reset while running, i_step high through release
    rst_n = 0;
    repeat (2) tick();
    chk("rr_digit", int'(o_digit), 0);
    chk("rr_state", int'(o_state), 0);
    chk("rr_tick", int'(o_tick), 0);
    i_run = 0; i_step = 1;
    tick();
    rst_n = 1;
    tick();
    chk("rel_step_digit", int'(o_digit), 1);
    chk("rel_step_tick", int'(o_tick), 1);
    repeat (4) tick();
    chk("held_step_once", int'(o_digit), 1);
    // step pulse inside RUN is ignored
    i_step = 0; i_run = 1;
    repeat (3) tick();
    i_step = 1;
    tick();
    chk("run_pulse_ignored", int'(o_digit), 1);
    i_step = 0;
    tick();
    chk("run_timed_step", int'(o_digit), 2);
    // manual down steps in HOLD through the 0 boundary
    i_run = 0;
    tick();
    i_dir = 0;
    for (int p = 0; p < 3; p++) begin
      i_step = 1;
      tick();
      if (p == 2) chk("manual_wrap", int'(o_wrap), 1);
      i_step = 0;
      tick();
    end
    chk("manual_digit", int'(o_digit), 9);
    i_load = 1; i_load_val = 4'd7;
    tick();
    i_load = 0;
    chk("hold_load_digit", int'(o_digit), 7);
    chk("hold_load_state", int'(o_state), 2);
    i_dir = 1;
    repeat (3) tick();
    chk("dir_no_step", int'(o_digit), 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter DIV_BASE, default 1000, meaning clk cycles per count step at i_rate=0 (legal range 2..2^24).
REQ-002 SHALL have parameter MAX_DIGIT, default 9, meaning the highest count value, with a legal range of 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on the posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_run, input, 1 bit: level; 1 = free-running count requested.
REQ-006 SHALL have port i_dir, input, 1 bit: 1 = up, 0 = down; sampled at every step.
REQ-007 SHALL have port i_step, input, 1 bit: manual single-step request; only the rising edge is used.
REQ-008 SHALL have port i_load, input, 1 bit: level; load i_load_val this cycle.
REQ-009 SHALL have port i_load_val, input, 4 bits: value to load.
REQ-010 SHALL have port i_rate, input, 2 bits: step period of DIV_BASE << i_rate cycles.
REQ-011 SHALL have port o_digit, output, 4 bits: current count, registered, always within 0..MAX_DIGIT.
REQ-012 SHALL have port o_tick, output, 1 bit: one-cycle strobe, high in the cycle o_digit shows a newly stepped value.
REQ-013 SHALL have port o_wrap, output, 1 bit: one-cycle strobe, coincident with o_tick when the step wrapped.
REQ-014 SHALL have port o_state, output, 2 bits: FSM state, encoded IDLE=00, RUN=01, HOLD=10.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and HOLD; encoding 11 is unreachable and SHALL recover to IDLE on the next cycle.
REQ-016 SHALL apply these FSM transitions: IDLE with i_run=1 -> RUN; RUN with i_run=0 -> HOLD; HOLD with i_run=1 -> RUN; all other conditions stay in the current state.
REQ-017 SHALL use a prescaler of at least 27 bits: in RUN it increments each cycle; in IDLE it is 0; in HOLD it is frozen.
REQ-018 SHALL compute the terminal count as T = (DIV_BASE << i_rate) - 1; in RUN, on the edge where prescaler >= T, the prescaler SHALL clear to 0 and one step SHALL be applied. A rate reduction mid-period therefore steps on the next edge.
REQ-019 SHALL define a step as follows: up, o_digit==MAX_DIGIT -> 0 with wrap; up otherwise -> +1; down, o_digit==0 -> MAX_DIGIT with wrap; down otherwise -> -1.
REQ-020 SHALL register o_tick and o_wrap on the same edge that updates o_digit; both SHALL be 0 in every cycle without a step.
REQ-021 SHALL detect a rising edge on i_step as i_step=1 with the registered previous i_step=0; in IDLE or HOLD, a rising edge SHALL apply one step; in RUN, it SHALL be ignored.
REQ-022 SHALL hold i_load above everything else except reset: o_digit <= min(i_load_val, MAX_DIGIT); prescaler <= 0; o_tick = o_wrap = 0; FSM state unchanged.
REQ-023 SHALL, when a timed step and a load occur in the same cycle, apply the load and drop the step.
REQ-024 SHALL NOT cause a step from an i_dir change alone; i_dir SHALL take effect only at the next step.

Reset
REQ-025 SHALL, when rst_n=0 at a posedge, set state to IDLE, o_digit to 0, prescaler to 0, o_tick and o_wrap to 0, and the i_step history register to 0.
REQ-026 SHALL give reset priority over i_load, i_step and i_run, and reset SHALL abort any partial prescaler period.
REQ-027 SHALL make the first cycle after rst_n rises behave as IDLE; if i_step is held high through reset release, that counts as a rising edge.

Verification (DIV_BASE=4, MAX_DIGIT=9)
REQ-028 SHALL cover: hold rst_n=0 for 2 cycles in RUN with o_digit=5 -> next cycle o_digit=0, o_state=00, o_tick=0.
REQ-029 SHALL cover: i_run=1, i_dir=1, i_rate=0 from 0 -> o_tick every 4 cycles, o_digit 1..9 then 0, with o_wrap=1 only on the 9->0 step.
REQ-030 SHALL cover: i_dir=0 at o_digit=0, i_rate=1 -> after 8 cycles o_digit=9 with o_wrap=1; the next step after 8 more cycles gives o_digit=8.
REQ-031 SHALL cover: i_load=1, i_load_val=12 -> o_digit=9; also assert i_load on a terminal-count cycle with i_load_val=3 -> o_digit=3, o_tick=0, and the next step 4 cycles later.
REQ-032 SHALL cover: in RUN, drop i_run with prescaler=2 and wait 10 cycles -> o_digit unchanged, o_state=10; then raise i_run -> step occurs 2 cycles later.
REQ-033 SHALL cover: in IDLE, i_step held high for 5 cycles -> exactly one step and one o_tick; i_step pulsed in RUN -> no extra step.
